wb_mem_responder: RTL
=====================

Name: wb_mem_responder

Overview:
Wishbone classic responder modelling the instruction and data memory that sits on the far side of the core's `wb_imem_*` and `wb_dmem_*` initiator ports. It is used in simulation benches and FPGA smoke builds. It has one word-addressed RAM with two independent ports: a read-only imem port and a read/write dmem port with byte enables. Each port has its own latency-counting FSM, so imem and dmem transfers proceed concurrently.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; must be a power of two.
- LATENCY, 0, extra wait cycles inserted before ack on both ports (0..15).
- BASE_ADR, 32'h0, byte address mapped to RAM word 0.
- INIT_FILE, "", hex file loaded into the RAM at elaboration; empty means all zeros.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- imem_cyc_i  in  1  imem bus cycle.
- imem_stb_i  in  1  imem strobe.
- imem_adr_i  in  32  imem byte address.
- imem_dat_o  out  32  imem read data.
- imem_ack_o  out  1  imem acknowledge.
- dmem_cyc_i  in  1  dmem bus cycle.
- dmem_stb_i  in  1  dmem strobe.
- dmem_we_i  in  1  dmem write enable.
- dmem_sel_i  in  4  dmem byte enables; bit n covers bits [8n+7:8n].
- dmem_adr_i  in  32  dmem byte address.
- dmem_dat_i  in  32  dmem write data.
- dmem_dat_o  out  32  dmem read data.
- dmem_ack_o  out  1  dmem acknowledge.
- err_o  out  1  sticky flag: an out-of-range access has occurred.

Behaviour:
- Reset: all FSMs go to IDLE. `imem_ack_o`=0, `dmem_ack_o`=0, `imem_dat_o`=0, `dmem_dat_o`=0, `err_o`=0, wait counters=0. RAM contents are not cleared.
- Request condition per port: `cyc_i & stb_i` while the FSM is in IDLE. Address, `we`, `sel` and write data are captured on that edge.
- Word index = (adr - BASE_ADR) >> 2. Address bits [1:0] are ignored.
- A request is in range when BASE_ADR <= adr < BASE_ADR + 4*MEM_WORDS.
- FSM per port: IDLE -> WAIT -> ACK -> IDLE.
  - IDLE -> WAIT on a request; the counter is loaded with LATENCY.
  - WAIT decrements the counter. It goes to ACK when the counter is 0; with LATENCY=0 the FSM spends exactly one cycle in WAIT.
  - ACK drives ack=1 for exactly one cycle, then returns to IDLE.
- Latency: request sampled at edge k gives ack high during cycle k+2+LATENCY (edges k+1+LATENCY .. k+2+LATENCY).
- Back-to-back transfers: if stb is still high in the cycle after ack, it is a new request and is sampled from IDLE. This gives a sustained throughput of one transfer per 3+LATENCY cycles.
- Abort: if cyc or stb falls while in WAIT, the FSM returns to IDLE. No ack, no write, `dat_o` unchanged.
- RAM operations take place on the edge that raises ack:
  - Read: `dat_o` loads RAM[word]. It holds that value until the next ack on the same port.
  - Write (dmem, we=1): each byte with sel[n]=1 is updated; bytes with sel=0 are unchanged. `dmem_dat_o` loads the pre-write word.
- Out of range: the transfer still acks with normal timing. Read data is 32'h0, the write is dropped, and `err_o` is set to 1 and stays set until reset.
- imem writes are impossible; the imem port has no we input.
- Same word, same edge, imem read and dmem write: imem returns the old data (read-before-write). The write is visible to any later read.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately, ack stays 0, and a pending write is discarded.
- ack is never asserted unless cyc & stb were high at the request edge and stayed high through WAIT. This makes the block a legal responder for the core's formal harness constraints: ack is low in reset and low while no cycle is active.

Test Plan:
- Reset, then imem read at 0x0 with RAM[0]=32'h00000013 and LATENCY=0 -> imem_ack_o high in the 2nd cycle after the request edge, imem_dat_o=32'h00000013.
- dmem write to 0x10 with dat 32'hAABBCCDD and sel 4'b0101 over RAM word 32'h11223344, then a dmem read of 0x10 -> 32'h11BB33DD; the write-cycle dmem_dat_o is 32'h11223344.
- LATENCY=3 build, imem read and dmem read issued on the same edge -> both acks rise on the same cycle, 5 cycles after the request edge, each carrying its own data.
- dmem write with stb dropped one cycle into WAIT (LATENCY=3) -> no ack, a subsequent read returns the unchanged word, err_o=0.
- dmem read at BASE_ADR + 4*MEM_WORDS -> ack with normal latency, dmem_dat_o=0, err_o=1 and it stays 1 through later valid accesses until reset.
- Reset asserted while dmem is in WAIT on a write to 0x20 -> dmem_ack_o stays 0, RAM[8] is unchanged; the first request after reset release behaves normally.

Source files
------------

// File: rtl/wb_mem_responder_if.sv
// Wishbone classic imem (read-only) and dmem (read/write) bus pair plus sticky error flag.
// The master modport drives requests; the slave modport returns data, ack and err.
interface wb_mem_responder_if;
    logic        imem_cyc_i;
    logic        imem_stb_i;
    logic [31:0] imem_adr_i;
    logic [31:0] imem_dat_o;
    logic        imem_ack_o;
    logic        dmem_cyc_i;
    logic        dmem_stb_i;
    logic        dmem_we_i;
    logic [3:0]  dmem_sel_i;
    logic [31:0] dmem_adr_i;
    logic [31:0] dmem_dat_i;
    logic [31:0] dmem_dat_o;
    logic        dmem_ack_o;
    logic        err_o;

    modport master (
        output imem_cyc_i, imem_stb_i, imem_adr_i,
        output dmem_cyc_i, dmem_stb_i, dmem_we_i, dmem_sel_i, dmem_adr_i, dmem_dat_i,
        input  imem_dat_o, imem_ack_o, dmem_dat_o, dmem_ack_o, err_o
    );

    modport slave (
        input  imem_cyc_i, imem_stb_i, imem_adr_i,
        input  dmem_cyc_i, dmem_stb_i, dmem_we_i, dmem_sel_i, dmem_adr_i, dmem_dat_i,
        output imem_dat_o, imem_ack_o, dmem_dat_o, dmem_ack_o, err_o
    );
endinterface

// File: rtl/wb_mem_responder.sv
// Dual-port Wishbone memory responder: ack in cycle k+2+LATENCY after request edge k,
// one transfer per 3+LATENCY cycles per port; dropping cyc/stb during WAIT aborts the transfer.
module wb_mem_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 0,
    parameter logic [31:0] BASE_ADR  = 32'h0,
    parameter string       INIT_FILE = ""
) (
    input logic               clock,
    input logic               reset,
    wb_mem_responder_if.slave bus
);
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    logic [31:0] mem [MEM_WORDS];

    state_t      i_state, i_next, d_state, d_next;
    logic [3:0]  i_cnt, i_cnt_next, d_cnt, d_cnt_next;
    logic        i_req, d_req, i_fire, d_fire;
    logic [31:0] i_adr, d_adr, d_wdat;
    logic [3:0]  d_sel;
    logic        d_we;
    logic [31:0] i_off, d_off;
    logic        i_ok, d_ok;
    logic [AW-1:0] i_idx, d_idx;
    logic [31:0] i_dat, d_dat;
    logic        err;

    assign i_req = bus.imem_cyc_i & bus.imem_stb_i;
    assign d_req = bus.dmem_cyc_i & bus.dmem_stb_i;

    always_comb begin
        i_next     = i_state;
        i_cnt_next = i_cnt;
        i_fire     = 1'b0;
        case (i_state)
            IDLE: if (i_req) begin
                i_next     = WAIT;
                i_cnt_next = 4'(LATENCY);
            end
            WAIT: if (!i_req) begin
                i_next = IDLE;
            end else if (i_cnt == 4'd0) begin
                i_next = ACK;
                i_fire = 1'b1;
            end else begin
                i_cnt_next = i_cnt - 4'd1;
            end
            default: i_next = IDLE;
        endcase
    end

    always_comb begin
        d_next     = d_state;
        d_cnt_next = d_cnt;
        d_fire     = 1'b0;
        case (d_state)
            IDLE: if (d_req) begin
                d_next     = WAIT;
                d_cnt_next = 4'(LATENCY);
            end
            WAIT: if (!d_req) begin
                d_next = IDLE;
            end else if (d_cnt == 4'd0) begin
                d_next = ACK;
                d_fire = 1'b1;
            end else begin
                d_cnt_next = d_cnt - 4'd1;
            end
            default: d_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            i_state <= IDLE;
            i_cnt   <= '0;
            d_state <= IDLE;
            d_cnt   <= '0;
        end else begin
            i_state <= i_next;
            i_cnt   <= i_cnt_next;
            d_state <= d_next;
            d_cnt   <= d_cnt_next;
        end
    end

    // Request attributes are frozen at the sampling edge so the master may change them during WAIT.
    always_ff @(posedge clock) begin
        if (i_state == IDLE && i_req) begin
            i_adr <= bus.imem_adr_i;
        end
        if (d_state == IDLE && d_req) begin
            d_adr  <= bus.dmem_adr_i;
            d_we   <= bus.dmem_we_i;
            d_sel  <= bus.dmem_sel_i;
            d_wdat <= bus.dmem_dat_i;
        end
    end

    // Offsets below BASE_ADR wrap to large values and so fail the single unsigned bound check.
    assign i_off = i_adr - BASE_ADR;
    assign d_off = d_adr - BASE_ADR;
    assign i_ok  = {1'b0, i_off} < MEM_BYTES;
    assign d_ok  = {1'b0, d_off} < MEM_BYTES;
    assign i_idx = i_off[AW+1:2];
    assign d_idx = d_off[AW+1:2];

    always_ff @(posedge clock) begin
        if (reset) begin
            i_dat <= '0;
            d_dat <= '0;
            err   <= 1'b0;
        end else begin
            if (i_fire) begin
                i_dat <= i_ok ? mem[i_idx] : 32'h0;
            end
            if (d_fire) begin
                d_dat <= d_ok ? mem[d_idx] : 32'h0;
            end
            if ((i_fire && !i_ok) || (d_fire && !d_ok)) begin
                err <= 1'b1;
            end
        end
    end

    // Non-blocking write keeps a same-edge imem read of this word returning the old contents.
    always_ff @(posedge clock) begin
        if (d_fire && d_we && d_ok && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (d_sel[b]) begin
                    mem[d_idx][8*b +: 8] <= d_wdat[8*b +: 8];
                end
            end
        end
    end

    assign bus.imem_ack_o = (i_state == ACK);
    assign bus.dmem_ack_o = (d_state == ACK);
    assign bus.imem_dat_o = i_dat;
    assign bus.dmem_dat_o = d_dat;
    assign bus.err_o      = err;
endmodule
